// File: rtl/glitc_scaler_readout.sv
// Gate timer, update pulse and snapshot capture for the dual trigger scalers.
// Optional IRQ output enabled by GLITC_SCALER_READOUT_IRQ_EN.
module glitc_scaler_readout #(
  parameter int NPAIR         = 4,
  parameter int GATE_CYCLES   = 50000000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  output logic                        hsk_update_o,
  input  logic [24*NPAIR-1:0]         upper_scaler_i,
  input  logic [24*NPAIR-1:0]         lower_scaler_i,
  input  logic                        update_req_i,
  input  logic                        rd_i,
  input  logic [$clog2(2*NPAIR):0]    addr_i,
  output logic [31:0]                 data_o,
  output logic                        ack_o,
  output logic                        busy_o
`ifdef GLITC_SCALER_READOUT_IRQ_EN
  ,
  output logic                        irq_o,
  input  logic                        irq_mask_i
`endif
);

  localparam int NCH = 2 * NPAIR;
  localparam int CW  = $clog2(NCH);
  localparam int AW  = CW + 1;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [SW-1:0]     set_q;
  logic              pend_q;
  logic              upd_q;
  logic              busy_q;
  logic              tick;
  logic              gate;

  logic [23:0]       hold_q [NCH];
  logic [NCH-1:0]    sat_q;
  logic [NCH-1:0]    new_q;
  logic [31:0]       data_q;
  logic              ack_q;

  logic [CW-1:0]     ch;
  logic              in_rng;

  assign tick   = (cnt_q == CNT_W'(GATE_CYCLES - 1));
  assign gate   = tick | update_req_i;
  assign cnt_d  = gate ? '0 : cnt_q + CNT_W'(1);
  assign ch     = addr_i[CW-1:0];
  assign in_rng = (addr_i < AW'(NCH));

  // Free-running gate counter; a manual request restarts the gate.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Update/settle/capture sequencer with one-deep request merging.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      pend_q  <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (state_q != S_IDLE) pend_q <= pend_q | gate;
      unique case (state_q)
        S_IDLE: begin
          if (gate || pend_q) begin
            state_q <= S_UPDATE;
            upd_q   <= 1'b1;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        S_UPDATE: begin
          state_q <= S_SETTLE;
          set_q   <= '0;
        end
        S_SETTLE: begin
          set_q <= set_q + SW'(1);
          if (set_q == SW'(SETTLE_CYCLES - 1)) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Register reads, then snapshot capture (capture's new-flag set wins).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NCH; i++) hold_q[i] <= '0;
      sat_q  <= '0;
      new_q  <= '0;
      data_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= rd_i;
      if (rd_i) begin
        if (in_rng) begin
          data_q    <= {new_q[ch], sat_q[ch], 6'b0, hold_q[ch]};
          new_q[ch] <= 1'b0;
        end else begin
          data_q <= '0;
        end
      end
      if (state_q == S_CAPTURE) begin
        for (int k = 0; k < NPAIR; k++) begin
          hold_q[2*k]   <= upper_scaler_i[24*k +: 24];
          hold_q[2*k+1] <= lower_scaler_i[24*k +: 24];
          sat_q[2*k]    <= upper_scaler_i[24*k+23];
          sat_q[2*k+1]  <= lower_scaler_i[24*k+23];
          new_q[2*k]    <= 1'b1;
          new_q[2*k+1]  <= 1'b1;
        end
      end
    end
  end

  assign hsk_update_o = upd_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;
  assign ack_o        = ack_q;

`ifdef GLITC_SCALER_READOUT_IRQ_EN
  logic irq_q;

  // Interrupt pulse the cycle after capture, unless masked.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= (state_q == S_CAPTURE) && !irq_mask_i;
  end

  assign irq_o = irq_q;
`endif

endmodule
